// File: rtl/cla16_result_checker.sv
// rtl/cla16_result_checker.sv - golden-model checker for the 16-bit CLA adder output
module cla16_result_checker #(
    parameter int WIDTH       = 16,
    parameter int DUT_LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             mismatch,
    output logic             err,
    output logic [15:0]      check_cnt,
    output logic [15:0]      err_cnt,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b,
    output logic             first_cin,
    output logic [WIDTH:0]   first_obs,
    output logic [WIDTH:0]   first_exp
);
    localparam int XW = WIDTH + 1;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_FAIL = 1'b1
    } state_t;

    state_t          state;
    logic [XW-1:0]   exp_now;
    logic [XW-1:0]   obs;
    logic            cmp_valid;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic            cmp_cin;
    logic [XW-1:0]   cmp_exp;
    logic            is_mis;

    assign exp_now = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign obs     = {cout, sum};

    generate
        if (DUT_LATENCY == 0) begin : g_direct
            assign cmp_valid = valid;
            assign cmp_a     = a;
            assign cmp_b     = b;
            assign cmp_cin   = cin;
            assign cmp_exp   = exp_now;
        end else begin : g_pipe
            logic [DUT_LATENCY-1:0]            pv;
            logic [DUT_LATENCY-1:0][WIDTH-1:0] pa;
            logic [DUT_LATENCY-1:0][WIDTH-1:0] pb;
            logic [DUT_LATENCY-1:0]            pc;
            logic [DUT_LATENCY-1:0][XW-1:0]    pe;

            // clear only needs to kill the valids; stale payload is never compared
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pv <= '0;
                    pa <= '0;
                    pb <= '0;
                    pc <= '0;
                    pe <= '0;
                end else if (clear) begin
                    pv <= '0;
                end else begin
                    pv[0] <= valid;
                    pa[0] <= a;
                    pb[0] <= b;
                    pc[0] <= cin;
                    pe[0] <= exp_now;
                    for (int i = 1; i < DUT_LATENCY; i++) begin
                        pv[i] <= pv[i-1];
                        pa[i] <= pa[i-1];
                        pb[i] <= pb[i-1];
                        pc[i] <= pc[i-1];
                        pe[i] <= pe[i-1];
                    end
                end
            end

            assign cmp_valid = pv[DUT_LATENCY-1];
            assign cmp_a     = pa[DUT_LATENCY-1];
            assign cmp_b     = pb[DUT_LATENCY-1];
            assign cmp_cin   = pc[DUT_LATENCY-1];
            assign cmp_exp   = pe[DUT_LATENCY-1];
        end
    endgenerate

    // case inequality so an X/Z result is flagged in simulation
    assign is_mis = cmp_valid && (obs !== cmp_exp);
    assign err    = (state == ST_FAIL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_PASS;
            mismatch  <= 1'b0;
            check_cnt <= '0;
            err_cnt   <= '0;
            first_a   <= '0;
            first_b   <= '0;
            first_cin <= 1'b0;
            first_obs <= '0;
            first_exp <= '0;
        end else if (clear) begin
            state     <= ST_PASS;
            mismatch  <= 1'b0;
            check_cnt <= '0;
            err_cnt   <= '0;
            first_a   <= '0;
            first_b   <= '0;
            first_cin <= 1'b0;
            first_obs <= '0;
            first_exp <= '0;
        end else begin
            mismatch <= is_mis;
            if (cmp_valid && (check_cnt != 16'hFFFF))
                check_cnt <= check_cnt + 16'd1;
            if (is_mis && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 16'd1;
            if (is_mis && (state == ST_PASS)) begin
                state     <= ST_FAIL;
                first_a   <= cmp_a;
                first_b   <= cmp_b;
                first_cin <= cmp_cin;
                first_obs <= obs;
                first_exp <= cmp_exp;
            end
        end
    end
endmodule

// File: tb/tb_cla16_result_checker.sv
// tb/tb_cla16_result_checker.sv - scoreboard bench for cla16_result_checker at latency 0 and 2
module tb_cla16_result_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        clear_0, valid_0, cin_0, cout_0;
    logic [15:0] a_0, b_0, sum_0;
    logic        mismatch_0, err_0, first_cin_0;
    logic [15:0] check_cnt_0, err_cnt_0, first_a_0, first_b_0;
    logic [16:0] first_obs_0, first_exp_0;

    logic        clear_2, valid_2, cin_2, cout_2;
    logic [15:0] a_2, b_2, sum_2;
    logic        mismatch_2, err_2, first_cin_2;
    logic [15:0] check_cnt_2, err_cnt_2, first_a_2, first_b_2;
    logic [16:0] first_obs_2, first_exp_2;

    cla16_result_checker #(.WIDTH(16), .DUT_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear_0), .valid(valid_0),
        .a(a_0), .b(b_0), .cin(cin_0), .sum(sum_0), .cout(cout_0),
        .mismatch(mismatch_0), .err(err_0), .check_cnt(check_cnt_0), .err_cnt(err_cnt_0),
        .first_a(first_a_0), .first_b(first_b_0), .first_cin(first_cin_0),
        .first_obs(first_obs_0), .first_exp(first_exp_0)
    );

    cla16_result_checker #(.WIDTH(16), .DUT_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .clear(clear_2), .valid(valid_2),
        .a(a_2), .b(b_2), .cin(cin_2), .sum(sum_2), .cout(cout_2),
        .mismatch(mismatch_2), .err(err_2), .check_cnt(check_cnt_2), .err_cnt(err_cnt_2),
        .first_a(first_a_2), .first_b(first_b_2), .first_cin(first_cin_2),
        .first_obs(first_obs_2), .first_exp(first_exp_2)
    );

    typedef struct {
        int          at;
        int          dut;
        logic        mism;
        logic        err;
        logic [15:0] cc;
        logic [15:0] ec;
        logic [15:0] fa;
        logic [15:0] fb;
        logic        fc;
        logic [16:0] fo;
        logic [16:0] fe;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;

    task automatic push(input int at, input int dut, input logic mism, input logic err,
                        input logic [15:0] cc, input logic [15:0] ec,
                        input logic [15:0] fa, input logic [15:0] fb, input logic fc,
                        input logic [16:0] fo, input logic [16:0] fe);
        exp_t e;
        e.at = at; e.dut = dut; e.mism = mism; e.err = err; e.cc = cc; e.ec = ec;
        e.fa = fa; e.fb = fb; e.fc = fc; e.fo = fo; e.fe = fe;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int dut, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, dut, cyc, act, want);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.at < cyc) begin
                total++;
                $display("FAIL missed_expectation dut%0d: stamp %0d now %0d", e.dut, e.at, cyc);
            end else if (e.dut == 0) begin
                chk("mismatch",  0, 32'(mismatch_0),  32'(e.mism));
                chk("err",       0, 32'(err_0),       32'(e.err));
                chk("check_cnt", 0, 32'(check_cnt_0), 32'(e.cc));
                chk("err_cnt",   0, 32'(err_cnt_0),   32'(e.ec));
                chk("first_a",   0, 32'(first_a_0),   32'(e.fa));
                chk("first_b",   0, 32'(first_b_0),   32'(e.fb));
                chk("first_cin", 0, 32'(first_cin_0), 32'(e.fc));
                chk("first_obs", 0, 32'(first_obs_0), 32'(e.fo));
                chk("first_exp", 0, 32'(first_exp_0), 32'(e.fe));
            end else begin
                chk("mismatch",  2, 32'(mismatch_2),  32'(e.mism));
                chk("err",       2, 32'(err_2),       32'(e.err));
                chk("check_cnt", 2, 32'(check_cnt_2), 32'(e.cc));
                chk("err_cnt",   2, 32'(err_cnt_2),   32'(e.ec));
                chk("first_a",   2, 32'(first_a_2),   32'(e.fa));
                chk("first_b",   2, 32'(first_b_2),   32'(e.fb));
                chk("first_cin", 2, 32'(first_cin_2), 32'(e.fc));
                chk("first_obs", 2, 32'(first_obs_2), 32'(e.fo));
                chk("first_exp", 2, 32'(first_exp_2), 32'(e.fe));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] s, input logic co, input logic clr);
        valid_0 = v; a_0 = a; b_0 = b; cin_0 = c; sum_0 = s; cout_0 = co; clear_0 = clr;
    endtask

    task automatic set2(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] s, input logic co, input logic clr);
        valid_2 = v; a_2 = a; b_2 = b; cin_2 = c; sum_2 = s; cout_2 = co; clear_2 = clr;
    endtask

    int w;

    initial begin
        set0(0, 0, 0, 0, 0, 0, 0);
        set2(0, 0, 0, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // latency 0: pass, first failure, later failure, idle, clear with same-cycle valid
        set0(1, 16'd2, 16'd2, 1, 16'd5, 0, 0);
        push(cyc + 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        set0(1, 16'hFFFF, 16'd1, 0, 16'd0, 0, 0);
        push(cyc + 1, 0, 1, 1, 2, 1, 16'hFFFF, 16'd1, 0, 17'h0, 17'h10000);
        tick();
        set0(1, 16'd18, 16'd18, 0, 16'd37, 0, 0);
        push(cyc + 1, 0, 1, 1, 3, 2, 16'hFFFF, 16'd1, 0, 17'h0, 17'h10000);
        tick();
        set0(0, 0, 0, 0, 0, 0, 0);
        push(cyc + 1, 0, 0, 1, 3, 2, 16'hFFFF, 16'd1, 0, 17'h0, 17'h10000);
        tick();
        set0(1, 16'hFFFF, 16'd1, 0, 16'd0, 0, 1);
        push(cyc + 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set0(0, 0, 0, 0, 0, 0, 0);
        push(cyc + 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // latency 2: correctly delayed results
        set2(1, 16'd100, 16'd0, 1, 16'd0, 0, 0);
        tick();
        set2(1, 16'd2, 16'd3, 1, 16'd0, 0, 0);
        tick();
        set2(0, 0, 0, 0, 16'd101, 0, 0);
        push(cyc + 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        set2(0, 0, 0, 0, 16'd6, 0, 0);
        push(cyc + 1, 2, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        tick();
        set2(0, 0, 0, 0, 0, 0, 0);
        tick();

        // latency 2: results one cycle late, both checks fail
        set2(1, 16'd100, 16'd0, 1, 16'd0, 0, 0);
        tick();
        set2(1, 16'd2, 16'd3, 1, 16'd0, 0, 0);
        tick();
        set2(0, 0, 0, 0, 16'd0, 0, 0);
        push(cyc + 1, 2, 1, 1, 3, 1, 16'd100, 16'd0, 1, 17'h0, 17'd101);
        tick();
        set2(0, 0, 0, 0, 16'd101, 0, 0);
        push(cyc + 1, 2, 1, 1, 4, 2, 16'd100, 16'd0, 1, 17'h0, 17'd101);
        tick();
        set2(0, 0, 0, 0, 16'd6, 0, 0);
        push(cyc + 1, 2, 0, 1, 4, 2, 16'd100, 16'd0, 1, 17'h0, 17'd101);
        tick();

        // latency 2: clear with two in flight plus a compare in the same cycle
        set2(1, 16'd1, 16'd1, 0, 16'd0, 0, 0);
        tick();
        set2(1, 16'd2, 16'd2, 0, 16'd0, 0, 0);
        tick();
        set2(1, 16'd3, 16'd3, 0, 16'd2, 0, 1);
        push(cyc + 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set2(0, 0, 0, 0, 16'hDEAD, 1, 0);
        push(cyc + 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        push(cyc + 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set2(0, 0, 0, 0, 0, 0, 0);
        tick();

        // latency 0: 65540 consecutive failures saturate both counters
        w = cyc;
        push(w + 65534, 0, 1, 1, 16'hFFFE, 16'hFFFE, 16'hFFFF, 16'd1, 0, 17'h0, 17'h10000);
        push(w + 65535, 0, 1, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 0, 17'h0, 17'h10000);
        push(w + 65540, 0, 1, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 0, 17'h0, 17'h10000);
        push(w + 65541, 0, 0, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd1, 0, 17'h0, 17'h10000);
        set0(1, 16'hFFFF, 16'd1, 0, 16'd0, 0, 0);
        repeat (65540) tick();
        set0(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        // asynchronous reset mid-cycle while dut0 is in FAIL
        #2;
        rst = 1'b1;
        push(cyc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(cyc, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        set0(1, 16'd2, 16'd2, 1, 16'd5, 0, 0);
        push(cyc + 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        set0(0, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();

        if (sb.size() != 0) begin
            $display("FAIL unconsumed_expectations: %0d left, 0 required", sb.size());
            total += sb.size();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cla16_result_checker.md
# cla16_result_checker

Synthesizable self-checking monitor that sits at the output side of the 16-bit carry-lookahead adder. It consumes the operands driven into the adder and the sum/carry the adder returns, computes the golden result internally, and counts checks and mismatches. It also latches the first failing transaction for post-silicon or FPGA debug. It is the receiving end of the adder's stimulus/response interface: the stimulus source drives `a`, `b` and `cin`, and this block judges `sum` and `cout`.

## Interface
- `WIDTH`, 16, operand/sum width.
- `DUT_LATENCY`, 0, cycles from operand presentation to result validity at `sum`/`cout` (legal 0..4).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous clear of counters, sticky flag, capture and pipeline.
- `valid`  in  1  operands `a`/`b`/`cin` are a transaction this cycle.
- `a`, `b`  in  WIDTH  adder operands.
- `cin`  in  1  adder carry-in.
- `sum`  in  WIDTH  observed adder sum.
- `cout`  in  1  observed adder carry-out.
- `mismatch`  out  1  one-cycle pulse per failing check.
- `err`  out  1  sticky: at least one mismatch since reset/clear.
- `check_cnt`  out  16  completed checks, saturating.
- `err_cnt`  out  16  failed checks, saturating.
- `first_a`, `first_b`  out  WIDTH  operands of first failure.
- `first_cin`  out  1  carry-in of first failure.
- `first_obs`  out  WIDTH+1  {cout,sum} observed at first failure.
- `first_exp`  out  WIDTH+1  {cout,sum} expected at first failure.

## Operation
- Expected value: `exp = a + b + cin`, computed at WIDTH+1 bits with no truncation. Bit WIDTH is the expected carry-out.
- Delay line: `DUT_LATENCY` stages carry {valid, a, b, cin, exp}. The delayed valid marks a compare cycle. On a compare cycle, {cout,sum} sampled that cycle is compared against the delayed exp. With `DUT_LATENCY=0`, comparison uses the same-cycle operands.
- Back-to-back valids every cycle are supported. Every transaction is checked exactly once.
- Compare cycle results:
  - Every compare cycle: `check_cnt` += 1.
  - On mismatch: `err_cnt` += 1 and `mismatch` pulses.
  - Both counters saturate at 16'hFFFF and never wrap.
- Capture FSM:
  - PASS (reset state): the first mismatch loads the `first_*` registers and moves to FAIL.
  - FAIL: `first_*` are frozen. Later mismatches only count and pulse.
  - `err` is 1 exactly when the FSM is in FAIL.
  - Only `clear` or `rst` returns the FSM to PASS.
- `clear`:
  - Zeroes the counters and all `first_*` registers, deasserts `err`, and returns the FSM to PASS.
  - Flushes the delay line: all in-flight valids are dropped and never checked.
  - A compare occurring in the same cycle as `clear` is discarded and neither counted nor pulsed.
  - A new `valid` in the same cycle as `clear` is also discarded.
- X/Z on `sum`/`cout` during a compare counts as a mismatch (simulation only).

## Timing
- Reset values: `mismatch`=0, `err`=0, `check_cnt`=0, `err_cnt`=0, all `first_*`=0, delay line invalid.
- Reset asserts asynchronously, releases synchronously on the next edge. Reset mid-stream discards in-flight transactions.
- Compare happens in cycle t+`DUT_LATENCY` for a valid presented in cycle t.
- Registered outputs update at the edge ending the compare cycle: `mismatch`, counters, `err`, and `first_*` are visible in cycle t+`DUT_LATENCY`+1.
- `mismatch` is high for exactly one cycle per failure. It is high on consecutive cycles for consecutive failures.
- The first valid after `clear`/`rst` is accepted in the cycle following deassertion.

## Test plan
- `DUT_LATENCY`=0, a=2, b=2, cin=1, sum=5, cout=0 -> `check_cnt`=1, `err_cnt`=0, `err`=0, no `mismatch` pulse.
- a=16'hFFFF, b=1, cin=0, forced sum=0, cout=0 -> `mismatch` pulses 1 cycle, `err`=1, `first_exp`=17'h10000, `first_obs`=0. Then a=18, b=18, cin=0, sum=37 -> `err_cnt`=2, `first_*` unchanged (first_a=16'hFFFF).
- `DUT_LATENCY`=2, valids every cycle with a=100,b=0,cin=1 then a=2,b=3,cin=1, correct results delayed 2 cycles -> `check_cnt`=2, `err`=0. Shift results by one cycle instead -> both checks fail.
- Preload `err_cnt`/`check_cnt` near saturation, or run 65 540 failing checks -> both counters hold 16'hFFFF, and `mismatch` still pulses.
- `DUT_LATENCY`=2, `clear` asserted while two transactions are in flight and a compare is occurring -> all outputs 0, and the following two cycles produce no check.
- `rst` pulsed asynchronously mid-cycle during FAIL -> outputs reach reset values immediately, and checking resumes after release with `check_cnt` starting from 0.
